// File: rtl/multiword_add_sequencer_if.sv
// ============================================================================
// Module   : multiword_add_sequencer_if
// Purpose  : Request/result bundle for the multiword add/subtract sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface multiword_add_sequencer_if #(
  parameter int N     = 4,
  parameter int WORDS = 4
);
  logic                 start;
  logic                 op;
  logic [N*WORDS-1:0]   a;
  logic [N*WORDS-1:0]   b;
  logic                 busy;
  logic                 done;
  logic [N*WORDS-1:0]   sum;
  logic                 c_out;

  modport master (
    output start, op, a, b,
    input  busy, done, sum, c_out
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, sum, c_out
  );
endinterface

`default_nettype wire

// File: rtl/multiword_add_sequencer.sv
// ============================================================================
// Module   : multiword_add_sequencer
// Purpose  : Adds or subtracts two N*WORDS operands one N-bit word per cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multiword_add_sequencer #(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input  wire                          clk,
  input  wire                          rst,
  multiword_add_sequencer_if.slave     bus
);

  localparam int TOTAL = N * WORDS;
  localparam int IW    = $clog2(WORDS) + 1;
  localparam int SW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [IW-1:0]      idx_q;
  logic               carry_q;
  logic               op_q;
  logic [N-1:0]       a_q   [WORDS];
  logic [N-1:0]       b_q   [WORDS];
  logic [N-1:0]       res_q [WORDS];
  logic [TOTAL-1:0]   sum_q;
  logic               c_out_q;
  logic               done_q;
  logic               busy_q;

  logic [SW-1:0]      sel_d;
  logic [N-1:0]       b_eff_d;
  logic [N:0]         word_sum_d;
  logic [TOTAL-1:0]   result_d;

  assign sel_d      = idx_q[SW-1:0];
  // Subtraction is a + ~b + 1; the +1 comes from seeding the carry with op.
  assign b_eff_d    = op_q ? ~b_q[sel_d] : b_q[sel_d];
  assign word_sum_d = {1'b0, a_q[sel_d]} + {1'b0, b_eff_d} + {{N{1'b0}}, carry_q};

  // Completed result including the word being produced on this edge.
  always_comb begin
    result_d = '0;
    for (int w = 0; w < WORDS; w++) begin
      result_d[w*N +: N] = (SW'(w) == sel_d) ? word_sum_d[N-1:0] : res_q[w];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      op_q    <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      for (int w = 0; w < WORDS; w++) begin
        a_q[w]   <= '0;
        b_q[w]   <= '0;
        res_q[w] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            for (int w = 0; w < WORDS; w++) begin
              a_q[w] <= bus.a[w*N +: N];
              b_q[w] <= bus.b[w*N +: N];
            end
            op_q    <= bus.op;
            carry_q <= bus.op;
            idx_q   <= '0;
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          res_q[sel_d] <= word_sum_d[N-1:0];
          carry_q      <= word_sum_d[N];
          idx_q        <= idx_q + IW'(1);
          if (idx_q == LAST_IDX) begin
            state_q <= DONE;
            sum_q   <= result_d;
            c_out_q <= word_sum_d[N];
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.c_out = c_out_q;

endmodule

`default_nettype wire

// File: tb/tb_multiword_add_sequencer.sv
// ============================================================================
// Module   : tb_multiword_add_sequencer
// Purpose  : Directed scoreboard bench for the multiword add/subtract sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multiword_add_sequencer;

  localparam int N     = 4;
  localparam int WORDS = 4;

  logic clk;
  logic rst;

  multiword_add_sequencer_if #(.N(N), .WORDS(WORDS)) bus ();

  multiword_add_sequencer #(.N(N), .WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks    = 0;
  int          errors    = 0;
  int          done_seen = 0;
  logic [16:0] exp_q [$];
  logic [15:0] last_sum  = 16'h0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expected result.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got sum 0x%0h with no expected entry", bus.sum);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        chk("sum", 32'(bus.sum), 32'(e[15:0]));
        chk("c_out", 32'(bus.c_out), 32'(e[16]));
      end
    end
  end

  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic top,
                        input logic [15:0] es, input logic ec, input bit disturb);
    int lat;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = ta;
    bus.b     = tb_v;
    bus.op    = top;
    exp_q.push_back({ec, es});
    @(posedge clk); #1;
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    chk("sum_hold_in_run", 32'(bus.sum), 32'(last_sum));
    bus.start = 1'b0;
    if (disturb) begin
      bus.a     = 16'hFFFF;
      bus.b     = 16'hFFFF;
      bus.op    = ~top;
      bus.start = 1'b1;
    end
    lat = 0;
    for (int j = 1; j <= 20; j++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        lat = j;
        break;
      end
    end
    chk("latency", 32'(lat), 32'(WORDS));
    if (disturb) bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("done_one_cycle", 32'(bus.done), 32'd0);
    chk("idle_after_done", 32'(bus.busy), 32'd0);
    last_sum = es;
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_sum", 32'(bus.sum), 32'h0);
    chk("rst_c_out", 32'(bus.c_out), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);

    run_op(16'h0006, 16'h000B, 1'b0, 16'h0011, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op(16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0);
    run_op(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b1);

    // Reset two RUN edges into an operation; start is held high during reset.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'h00FF;
    bus.b     = 16'h0001;
    bus.op    = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst       = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    chk("midrst_sum", 32'(bus.sum), 32'h0);
    chk("midrst_c_out", 32'(bus.c_out), 32'h0);
    chk("midrst_busy", 32'(bus.busy), 32'h0);
    chk("midrst_done", 32'(bus.done), 32'h0);
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_idle", 32'(bus.busy), 32'h0);
    last_sum = 16'h0000;

    run_op(16'h0002, 16'h0003, 1'b0, 16'h0005, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("done_pulse_count", 32'(done_seen), 32'd7);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multiword_add_sequencer.md
MULTIWORD_ADD_SEQUENCER -- requirements
Module: multiword_add_sequencer

Interface
REQ-001 SHALL have parameter N, default 4: width in bits of the per-cycle add slice.
REQ-002 SHALL have parameter WORDS, default 4: number of N-bit words per operand; total operand width is N*WORDS.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1: request to begin an operation; sampled only in IDLE.
REQ-006 SHALL have port op, input, 1: 0 = add (a+b), 1 = subtract (a-b); sampled with start.
REQ-007 SHALL have port a, input, N*WORDS: operand A; sampled with start.
REQ-008 SHALL have port b, input, N*WORDS: operand B; sampled with start.
REQ-009 SHALL have port busy, output, 1: high whenever the state is not IDLE.
REQ-010 SHALL have port done, output, 1: one-cycle pulse marking a valid new result.
REQ-011 SHALL have port sum, output, N*WORDS: registered result.
REQ-012 SHALL have port c_out, output, 1: final carry for add, or the no-borrow flag for subtract.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 IDLE, start=1 at edge k: SHALL latch a, b, op; SHALL set word index to 0; SHALL set the carry register to op; SHALL go to RUN.
REQ-015 IDLE, start=0: SHALL stay in IDLE; all registers SHALL hold.
REQ-016 RUN, each edge: SHALL compute word idx as A[idx] + B'[idx] + carry in N+1-bit arithmetic, where B' = B for add and ~B for subtract.
REQ-017 RUN, each edge: SHALL write the low N bits of that result to the internal result word idx, store bit N as carry, and increment idx.
REQ-018 Exactly one N-bit word SHALL be processed per cycle, least-significant word first.
REQ-019 RUN, edge where idx = WORDS-1: SHALL go to DONE; SHALL load sum from the completed internal result; SHALL load c_out from the final carry; SHALL assert done.
REQ-020 Latency: start accepted at edge k SHALL make done=1 after edge k+WORDS, high for exactly one cycle.
REQ-021 DONE: SHALL return to IDLE on the next edge, with done=0.
REQ-022 sum and c_out SHALL change only at the DONE entry edge; they SHALL hold the previous result throughout IDLE and RUN.
REQ-023 start SHALL be ignored in RUN and DONE; no queuing; earliest next acceptance is the first IDLE cycle.
REQ-024 Changes on a, b or op after the start edge SHALL NOT affect the result in progress.
REQ-025 Result SHALL equal (a + b) mod 2^(N*WORDS) for add, or (a - b) mod 2^(N*WORDS) for subtract.
REQ-026 Add: c_out SHALL be 1 iff a + b >= 2^(N*WORDS).
REQ-027 Subtract: c_out SHALL be 1 iff a >= b (unsigned).
REQ-028 idx SHALL be ceil(log2(WORDS))+1 bits wide (minimum 1) and SHALL NOT wrap within an operation.
REQ-029 WORDS=1 SHALL be supported: RUN lasts one cycle; done appears after edge k+1.

Reset
REQ-030 rst=1 at any edge, including mid-RUN or in DONE, SHALL force: state IDLE; busy=0; done=0; sum=0; c_out=0; idx=0; carry=0; internal operand and result registers=0.
REQ-031 rst SHALL take priority over start; an operation interrupted by reset SHALL produce no done pulse.
REQ-032 start asserted while rst=1 SHALL be discarded.

Verification (N=4, WORDS=4)
REQ-033 Reset: hold rst for 2 edges, then release -> sum=0x0000, c_out=0, busy=0, done=0.
REQ-034 Add: a=0x0006, b=0x000B, op=0, start at edge k -> busy=1 from edge k; done=1 after edge k+4 only; sum=0x0011, c_out=0.
REQ-035 Full carry ripple: a=0xFFFF, b=0x0001, op=0 -> sum=0x0000, c_out=1; a=0x8000, b=0x8000 -> sum=0x0000, c_out=1.
REQ-036 Subtract: a=0x0005, b=0x0007, op=1 -> sum=0xFFFE, c_out=0; a=0x0007, b=0x0005, op=1 -> sum=0x0002, c_out=1.
REQ-037 Busy rejection: start with a=0x1234, b=0x1111; during RUN change a/b to 0xFFFF and pulse start -> sum=0x2345, exactly one done pulse; next start accepted only in IDLE.
REQ-038 Reset mid-run: start with a=0x00FF, b=0x0001; assert rst after 2 RUN edges -> no done pulse; sum=0x0000, c_out=0, state IDLE; a following add of 0x0002+0x0003 -> sum=0x0005.
